// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - CPU, cache-array and memory-port signal bundle for cache_controller
interface cache_controller_if;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_byte_en;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;

    logic         cache_enable;
    logic         cache_write;
    logic         cache_compare;
    logic [31:0]  cache_addr;
    logic [31:0]  cache_data_in;
    logic [3:0]   cache_byte_w_en;
    logic [255:0] cache_line_in;
    logic         cache_hit;
    logic         cache_dirty;
    logic         cache_valid;
    logic [19:0]  cache_tag;
    logic [31:0]  cache_data_out;
    logic [255:0] cache_line_out;

    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wline;
    logic [255:0] mem_rline;
    logic         mem_ack;

    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    // slave: the controller; master: CPU, array and memory around it
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
        output cpu_ready, cpu_rdata,
        output cache_enable, cache_write, cache_compare, cache_addr,
        output cache_data_in, cache_byte_w_en, cache_line_in,
        input  cache_hit, cache_dirty, cache_valid, cache_tag,
        input  cache_data_out, cache_line_out,
        output mem_req, mem_we, mem_addr, mem_wline,
        input  mem_rline, mem_ack,
        output hit_count, miss_count
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
        input  cpu_ready, cpu_rdata,
        input  cache_enable, cache_write, cache_compare, cache_addr,
        input  cache_data_in, cache_byte_w_en, cache_line_in,
        output cache_hit, cache_dirty, cache_valid, cache_tag,
        output cache_data_out, cache_line_out,
        input  mem_req, mem_we, mem_addr, mem_wline,
        output mem_rline, mem_ack,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - L1 D-cache miss controller: hit lookup, dirty writeback, refill, install
module cache_controller (
    input  logic               clk,
    input  logic               rst,
    cache_controller_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, INSTALL} state_t;

    state_t        state_q, state_d;
    logic          req_we_q, req_we_d;
    logic          retry_q, retry_d;
    logic [19:0]   wb_tag_q, wb_tag_d;
    logic [255:0]  wb_line_q, wb_line_d;
    logic [31:0]   cache_addr_q, cache_addr_d;
    logic [31:0]   cache_data_in_q, cache_data_in_d;
    logic [3:0]    cache_byte_w_en_q, cache_byte_w_en_d;
    logic          cache_enable_q, cache_enable_d;
    logic          cache_write_q, cache_write_d;
    logic          cache_compare_q, cache_compare_d;
    logic [255:0]  cache_line_in_q, cache_line_in_d;
    logic          cpu_ready_q, cpu_ready_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [255:0]  mem_wline_q, mem_wline_d;
    logic [31:0]   hit_count_q, hit_count_d;
    logic [31:0]   miss_count_q, miss_count_d;
    logic          mem_done;
    logic          mem_active;

    assign mem_done = mem_req_q && bus.mem_ack;

    always_comb begin
        state_d           = state_q;
        req_we_d          = req_we_q;
        retry_d           = retry_q;
        wb_tag_d          = wb_tag_q;
        wb_line_d         = wb_line_q;
        cache_addr_d      = cache_addr_q;
        cache_data_in_d   = cache_data_in_q;
        cache_byte_w_en_d = cache_byte_w_en_q;
        cache_line_in_d   = '0;
        cpu_ready_d       = 1'b0;
        cpu_rdata_d       = '0;
        hit_count_d       = hit_count_q;
        miss_count_d      = miss_count_q;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    cache_addr_d      = bus.cpu_addr;
                    req_we_d          = bus.cpu_we;
                    cache_data_in_d   = bus.cpu_wdata;
                    cache_byte_w_en_d = bus.cpu_byte_en;
                    state_d           = COMPARE;
                end
            end
            COMPARE: begin
                if (bus.cache_hit) begin
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = bus.cache_data_out;
                    if (!retry_q) hit_count_d = hit_count_q + 32'd1;
                    retry_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    miss_count_d = miss_count_q + 32'd1;
                    if (bus.cache_valid && bus.cache_dirty) begin
                        wb_tag_d  = bus.cache_tag;
                        wb_line_d = bus.cache_line_out;
                        state_d   = WRITEBACK;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            WRITEBACK: if (mem_done) state_d = REFILL;
            REFILL: begin
                if (mem_done) begin
                    cache_line_in_d = bus.mem_rline;
                    state_d         = INSTALL;
                end
            end
            INSTALL: begin
                retry_d = 1'b1;
                state_d = COMPARE;
            end
            default: state_d = IDLE;
        endcase

        // Memory fields follow the current state, so mem_req rises one cycle into WRITEBACK/REFILL
        mem_active  = (state_q == WRITEBACK || state_q == REFILL) && !mem_done;
        mem_req_d   = mem_active;
        mem_we_d    = mem_active && (state_q == WRITEBACK);
        mem_addr_d  = '0;
        mem_wline_d = '0;
        if (mem_active && state_q == WRITEBACK) begin
            mem_addr_d  = {wb_tag_q, cache_addr_q[11:5], 5'b0};
            mem_wline_d = wb_line_q;
        end else if (mem_active) begin
            mem_addr_d  = {cache_addr_q[31:5], 5'b0};
        end

        // Array controls are registered from the next state so they line up with COMPARE/INSTALL
        cache_enable_d  = (state_d == COMPARE) || (state_d == INSTALL);
        cache_compare_d = (state_d == COMPARE);
        cache_write_d   = ((state_d == COMPARE) && req_we_d) || (state_d == INSTALL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            req_we_q          <= 1'b0;
            retry_q           <= 1'b0;
            wb_tag_q          <= '0;
            wb_line_q         <= '0;
            cache_addr_q      <= '0;
            cache_data_in_q   <= '0;
            cache_byte_w_en_q <= '0;
            cache_enable_q    <= 1'b0;
            cache_write_q     <= 1'b0;
            cache_compare_q   <= 1'b0;
            cache_line_in_q   <= '0;
            cpu_ready_q       <= 1'b0;
            cpu_rdata_q       <= '0;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_addr_q        <= '0;
            mem_wline_q       <= '0;
            hit_count_q       <= '0;
            miss_count_q      <= '0;
        end else begin
            state_q           <= state_d;
            req_we_q          <= req_we_d;
            retry_q           <= retry_d;
            wb_tag_q          <= wb_tag_d;
            wb_line_q         <= wb_line_d;
            cache_addr_q      <= cache_addr_d;
            cache_data_in_q   <= cache_data_in_d;
            cache_byte_w_en_q <= cache_byte_w_en_d;
            cache_enable_q    <= cache_enable_d;
            cache_write_q     <= cache_write_d;
            cache_compare_q   <= cache_compare_d;
            cache_line_in_q   <= cache_line_in_d;
            cpu_ready_q       <= cpu_ready_d;
            cpu_rdata_q       <= cpu_rdata_d;
            mem_req_q         <= mem_req_d;
            mem_we_q          <= mem_we_d;
            mem_addr_q        <= mem_addr_d;
            mem_wline_q       <= mem_wline_d;
            hit_count_q       <= hit_count_d;
            miss_count_q      <= miss_count_d;
        end
    end

    assign bus.cpu_ready       = cpu_ready_q;
    assign bus.cpu_rdata       = cpu_rdata_q;
    assign bus.cache_enable    = cache_enable_q;
    assign bus.cache_write     = cache_write_q;
    assign bus.cache_compare   = cache_compare_q;
    assign bus.cache_addr      = cache_addr_q;
    assign bus.cache_data_in   = cache_data_in_q;
    assign bus.cache_byte_w_en = cache_byte_w_en_q;
    assign bus.cache_line_in   = cache_line_in_q;
    assign bus.mem_req         = mem_req_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wline       = mem_wline_q;
    assign bus.hit_count       = hit_count_q;
    assign bus.miss_count      = miss_count_q;
endmodule

// File: doc/cache_controller.md
# cache_controller

Miss-handling controller for the two-way set-associative L1 data cache. It accepts word requests from the pipeline and drives the array's enable/write/compare/line interface, performing hit lookup, dirty-victim writeback and line refill. It sits between the CPU memory stage and the line-granular memory port, opposite the cache array. It also keeps hit and miss counters.

## Interface
- No parameters. Geometry is fixed: tag addr[31:12] (20 b), index addr[11:5] (7 b), word addr[4:2], 256-bit line.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  request valid; fields held stable until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  word address
- cpu_wdata  in  32  store data
- cpu_byte_en  in  4  store byte enables
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  load data, valid while cpu_ready=1
- cache_enable, cache_write, cache_compare  out  1 each  array control
- cache_addr  out  32  array address (latched request address)
- cache_data_in  out  32  store word
- cache_byte_w_en  out  4  store byte enables
- cache_line_in  out  256  refill line
- cache_hit, cache_dirty, cache_valid  in  1 each  array status (combinational from cache_addr)
- cache_tag  in  20  hit-way tag, else victim tag
- cache_data_out  in  32  hit word
- cache_line_out  in  256  hit line, else victim line
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = line write, 0 = line read
- mem_addr  out  32  line address, bits [4:0] = 0
- mem_wline  out  256  writeback line
- mem_rline  in  256  read line, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse from memory
- hit_count, miss_count  out  32 each  event counters, wrap modulo 2^32

## Operation
- The FSM has five states: IDLE, COMPARE, WRITEBACK, REFILL, INSTALL.
- **IDLE**
  - Cache and memory outputs are inactive.
  - When cpu_req=1, latch addr, we, wdata and byte_en, then go to COMPARE.
- **COMPARE**
  - Drive cache_enable=1, cache_compare=1, cache_write=latched we.
  - On hit, the array commits the store at the clock edge. Register cpu_rdata=cache_data_out and pulse cpu_ready on the next cycle. Increment hit_count unless this is a post-refill retry. Go to IDLE.
  - On miss: increment miss_count.
    - If cache_valid and cache_dirty: latch cache_tag and cache_line_out into the writeback buffer, then go to WRITEBACK.
    - Otherwise go to REFILL.
- **WRITEBACK**
  - Drive mem_req=1, mem_we=1, mem_addr={wb_tag, index, 5'b0}, mem_wline=writeback buffer.
  - On mem_ack, go to REFILL.
- **REFILL**
  - Drive mem_req=1, mem_we=0, mem_addr={addr[31:5], 5'b0}.
  - On mem_ack, latch mem_rline into the refill buffer, then go to INSTALL.
- **INSTALL** (one cycle)
  - Drive cache_enable=1, cache_compare=0, cache_write=1, cache_line_in=refill buffer.
  - The array writes the line into its victim way, marked valid and clean.
  - Set the retry flag and go to COMPARE. The retry hits and applies a pending store through the normal hit path.
- The set's valid/dirty state does not change between the miss COMPARE and INSTALL, so the array selects the same victim in both.
- cpu_req is sampled only in IDLE.

## Timing
- **Reset:** rst low forces, immediately, state=IDLE and all outputs 0, including both counters and the retry flag. An outstanding memory transaction is abandoned; memory must tolerate a dropped mem_req.
- **Hit latency:** cpu_req sampled at edge N, COMPARE runs in cycle N+1, cpu_ready=1 in cycle N+2.
  - In the cpu_ready cycle the FSM is already in IDLE, so cpu_req=1 in that cycle starts a new request (back-to-back throughput of one request per 2 cycles).
- **Clean miss:** 2 + refill wait + INSTALL + COMPARE + 1 cycles.
- **Dirty miss:** adds a full writeback handshake before the refill.
- **Memory handshake:**
  - mem_req rises the cycle after entering WRITEBACK/REFILL and stays asserted with stable fields until mem_ack.
  - mem_req drops the cycle after mem_ack.
  - mem_ack in the same cycle mem_req first rises is legal.
  - mem_ack while mem_req=0 is ignored.
- A store on hit writes the word and sets dirty at the COMPARE edge; cpu_rdata is don't-care for stores.
- Counters increment at most once per request; miss_count counts refills, not retries.

## Test plan
- **Reset:** assert rst low mid-cycle → all outputs 0 asynchronously; hit_count=miss_count=0.
- **Cold load miss:** load 0x0000_1048; memory returns a line with word2=0xDEADBEEF after 3 cycles → mem_req, mem_we=0, mem_addr=0x0000_1040; INSTALL then COMPARE; cpu_rdata=0xDEADBEEF; miss_count=1, hit_count=0.
- **Load hit:** repeat load 0x0000_1048 → cpu_ready exactly 2 cycles after request, no mem_req, hit_count=1.
- **Store hit merge:** store 0x12345678 with byte_en=4'b0011 to 0x0000_1048, then load the same address → 0xDEAD5678.
- **Dirty eviction:** make 0x0000_1048 and 0x0000_2048 dirty (both index 2), then load 0x0000_3048 → a writeback (mem_we=1) to 0x0000_1040 or 0x0000_2040 carrying the merged dirty line; then a refill read from 0x0000_3040; correct word returned.
- **Reset mid-refill:** pull rst low while waiting for mem_ack → mem_req falls immediately; after release, a new load completes normally.
